seg7_scan_display: RTL



---
 rtl/seg7_scan_display.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_display
//  Description : Samples a 4-bit counter value on a strobe and converts it to
//                two decimal digits (00-15). It drives a 2-digit common-anode
//                7-segment display by time-division scanning. A 15->0 wrap of
//                the counter is shown on the ones-digit decimal point.
//                Optional macro SEG7_LZ_BLANK_EN: when defined, a zero tens
//                digit is blanked while its digit select is still driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       oe,
  input  logic [3:0] din,
  input  logic       din_vld,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig_sel
);

  localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {
    S_ONES = 1'b0,
    S_TENS = 1'b1
  } state_t;

  // Registered state
  logic [3:0]       din_q,     din_d;
  logic             wrap_q,    wrap_d;
  logic             tens_q,    tens_d;
  logic [3:0]       ones_q,    ones_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  state_t           state_q,   state_d;
  logic [6:0]       seg_q,     seg_d;
  logic             dp_q,      dp_d;
  logic [1:0]       dig_sel_q, dig_sel_d;

  logic             tick;
  logic [6:0]       ones_seg;
  logic [6:0]       tens_seg;

  // Active-low {g,f,e,d,c,b,a} pattern for a single decimal digit
  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Capture, wrap tracking and BCD split of the captured value
  always_comb begin
    din_d  = din_q;
    wrap_d = wrap_q;
    if (din_vld) begin
      din_d = din;
      // Old value 15 followed by 0 is a wrap; any nonzero capture clears it.
      if ((din_q == 4'd15) && (din == 4'd0)) begin
        wrap_d = 1'b1;
      end else if (din != 4'd0) begin
        wrap_d = 1'b0;
      end
    end
    tens_d = (din_q >= 4'd10);
    ones_d = tens_d ? (din_q - 4'd10) : din_q;
  end

  // Prescaler and two-phase scan sequencing
  always_comb begin
    tick      = (div_cnt_q == CNT_MAX);
    div_cnt_d = tick ? '0 : (div_cnt_q + 1'b1);
    state_d   = state_q;
    if (tick) begin
      state_d = (state_q == S_ONES) ? S_TENS : S_ONES;
    end
  end

  // Next values of the registered display outputs
  always_comb begin
    ones_seg = enc(ones_q);
`ifdef SEG7_LZ_BLANK_EN
    tens_seg = tens_q ? enc(4'd1) : SEG_OFF;
`else
    tens_seg = enc({3'b000, tens_q});
`endif
    seg_d     = SEG_OFF;
    dp_d      = 1'b1;
    dig_sel_d = 2'b11;
    if (oe) begin
      if (state_q == S_ONES) begin
        dig_sel_d = 2'b10;
        seg_d     = ones_seg;
        dp_d      = ~wrap_q;
      end else begin
        dig_sel_d = 2'b01;
        seg_d     = tens_seg;
      end
    end
  end

  // All state and outputs, cleared immediately by clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      din_q     <= 4'd0;
      wrap_q    <= 1'b0;
      tens_q    <= 1'b0;
      ones_q    <= 4'd0;
      div_cnt_q <= '0;
      state_q   <= S_ONES;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      dig_sel_q <= 2'b11;
    end else begin
      din_q     <= din_d;
      wrap_q    <= wrap_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = dig_sel_q;

endmodule
`default_nettype wire
